tx_resp_sched: RTL and testbench
================================

TX_RESP_SCHED -- requirements
Module: tx_resp_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the byte width of all data paths.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port RD_DATA  input  DATA_WIDTH  register-file read result.
REQ-005 SHALL have port RD_DATA_VLD  input  1  one-cycle strobe qualifying RD_DATA.
REQ-006 SHALL have port ALU_OUT  input  2*DATA_WIDTH  ALU result.
REQ-007 SHALL have port ALU_OUT_VLD  input  1  one-cycle strobe qualifying ALU_OUT.
REQ-008 SHALL have port FIFO_FULL  input  1  TX FIFO cannot accept a write this cycle.
REQ-009 SHALL have port FIFO_WR  output  1  TX FIFO write strobe; a byte transfers on each rising edge where FIFO_WR=1.
REQ-010 SHALL have port TX_DATA_OUT  output  DATA_WIDTH  byte presented to the TX FIFO.
REQ-011 SHALL have port RD_PEND  output  1  read-response slot occupied.
REQ-012 SHALL have port ALU_PEND  output  1  ALU-response slot occupied.
REQ-013 SHALL have port OVERFLOW  output  1  sticky flag: a response was dropped.
REQ-014 SHALL have port CLR_OVF  input  1  synchronous clear of OVERFLOW.

Function
REQ-015 SHALL hold two response slots: RD slot (1 byte) and ALU slot (2 bytes), each a holding register plus pending bit driving RD_PEND/ALU_PEND.
REQ-016 SHALL capture RD_DATA into RD slot on the edge where RD_DATA_VLD=1 and the slot is free or its final byte is written that same edge; likewise ALU_OUT into ALU slot on ALU_OUT_VLD.
REQ-017 SHALL drop a strobe arriving when its slot is occupied and not freed that edge, leave the slot contents unchanged, and set OVERFLOW.
REQ-018 SHALL clear OVERFLOW on an edge with CLR_OVF=1, except that a simultaneous drop sets it (set wins).
REQ-019 SHALL implement FSM states IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI.
REQ-020 IDLE: if exactly one slot pending, go to its first SEND state; if both pending, grant the slot not granted last (round-robin) and record the grant; else stay.
REQ-021 SEND_RD: on FIFO_WR edge clear RD_PEND and go to IDLE.
REQ-022 SEND_ALU_LO: on FIFO_WR edge go to SEND_ALU_HI; SEND_ALU_HI: on FIFO_WR edge clear ALU_PEND and go to IDLE.
REQ-023 FIFO_WR SHALL be combinational: 1 iff state is a SEND state and FIFO_FULL=0; state SHALL hold while FIFO_FULL=1 (no byte lost or duplicated).
REQ-024 TX_DATA_OUT SHALL be combinational: RD byte in SEND_RD, ALU_OUT[DATA_WIDTH-1:0] in SEND_ALU_LO, ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH] in SEND_ALU_HI, all-zero in IDLE.
REQ-025 Latency: strobe in cycle c -> pending visible in c+1 -> SEND state in c+2 -> first FIFO_WR in c+2 if FIFO_FULL=0.
REQ-026 ALU bytes SHALL be written consecutively, low then high; no RD byte SHALL interleave between them.
REQ-027 Slot contents captured while SEND is in progress for the other slot SHALL NOT affect the byte currently presented.

Reset
REQ-028 On RST=0, asynchronously: state=IDLE, RD_PEND=0, ALU_PEND=0, OVERFLOW=0, holding registers=0, round-robin pointer = "ALU granted last" (RD wins the first tie); hence FIFO_WR=0, TX_DATA_OUT=0.
REQ-029 Reset mid-transfer SHALL abandon all pending responses; no FIFO_WR SHALL occur until a new strobe after RST=1.

Verification
REQ-030 RD_DATA=0x5A strobe, FIFO_FULL=0 -> exactly one FIFO_WR with TX_DATA_OUT=0x5A two cycles later; RD_PEND returns to 0.
REQ-031 ALU_OUT=0x1234 strobe, FIFO_FULL=0 -> FIFO_WR on two consecutive cycles carrying 0x34 then 0x12.
REQ-032 RD (0xAA) and ALU (0xBEEF) strobes same cycle, then again after drain -> order 0xAA,0xEF,0xBE then 0xEF,0xBE,0xAA (round-robin).
REQ-033 ALU 0x0102 strobe with FIFO_FULL=1 for 5 cycles after first SEND, then 0 -> no FIFO_WR while full; then 0x02,0x01 once each.
REQ-034 Second RD strobe (0x77) while RD slot pending and FIFO_FULL=1 -> dropped, OVERFLOW=1, original byte still sent; CLR_OVF pulse -> OVERFLOW=0.
REQ-035 RST asserted in SEND_ALU_HI -> outputs at reset values immediately; no high byte written after release.

Source files
------------

// File: rtl/tx_resp_sched.sv
// Response scheduler: buffers one register-read byte and one 2-byte ALU result
// and serialises them into the TX FIFO with round-robin arbitration on ties.
module tx_resp_sched #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RD_DATA,
    input  logic                      RD_DATA_VLD,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    input  logic                      FIFO_FULL,
    output logic                      FIFO_WR,
    output logic [DATA_WIDTH-1:0]     TX_DATA_OUT,
    output logic                      RD_PEND,
    output logic                      ALU_PEND,
    output logic                      OVERFLOW,
    input  logic                      CLR_OVF
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_RD,
        SEND_ALU_LO,
        SEND_ALU_HI
    } state_t;

    state_t                    state, state_nxt;
    logic                      last_alu, last_alu_nxt;
    logic [DATA_WIDTH-1:0]     rd_hold;
    logic [2*DATA_WIDTH-1:0]   alu_hold;
    logic                      rd_pend, alu_pend, ovf;

    logic rd_done, alu_done;
    logic rd_free, alu_free;
    logic rd_drop, alu_drop;

    // A slot may be refilled on the very edge its last byte leaves.
    assign rd_done  = (state == SEND_RD)     && FIFO_WR;
    assign alu_done = (state == SEND_ALU_HI) && FIFO_WR;
    assign rd_free  = !rd_pend  || rd_done;
    assign alu_free = !alu_pend || alu_done;
    assign rd_drop  = RD_DATA_VLD && !rd_free;
    assign alu_drop = ALU_OUT_VLD && !alu_free;

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt    = state;
        last_alu_nxt = last_alu;
        FIFO_WR      = 1'b0;
        TX_DATA_OUT  = '0;
        unique case (state)
            IDLE: begin
                if (rd_pend && alu_pend) begin
                    if (last_alu) begin
                        state_nxt    = SEND_RD;
                        last_alu_nxt = 1'b0;
                    end else begin
                        state_nxt    = SEND_ALU_LO;
                        last_alu_nxt = 1'b1;
                    end
                end else if (rd_pend) begin
                    state_nxt = SEND_RD;
                end else if (alu_pend) begin
                    state_nxt = SEND_ALU_LO;
                end
            end
            SEND_RD: begin
                FIFO_WR     = !FIFO_FULL;
                TX_DATA_OUT = rd_hold;
                if (!FIFO_FULL) state_nxt = IDLE;
            end
            SEND_ALU_LO: begin
                FIFO_WR     = !FIFO_FULL;
                TX_DATA_OUT = alu_hold[DATA_WIDTH-1:0];
                if (!FIFO_FULL) state_nxt = SEND_ALU_HI;
            end
            SEND_ALU_HI: begin
                FIFO_WR     = !FIFO_FULL;
                TX_DATA_OUT = alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
                if (!FIFO_FULL) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            last_alu <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_alu <= last_alu_nxt;
        end
    end

    // NOTE: the holding registers are reset as well so TX_DATA_OUT is
    // deterministic from the first cycle after reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_hold  <= '0;
            rd_pend  <= 1'b0;
            alu_hold <= '0;
            alu_pend <= 1'b0;
        end else begin
            if (RD_DATA_VLD && rd_free) begin
                rd_hold <= RD_DATA;
                rd_pend <= 1'b1;
            end else if (rd_done) begin
                rd_pend <= 1'b0;
            end
            if (ALU_OUT_VLD && alu_free) begin
                alu_hold <= ALU_OUT;
                alu_pend <= 1'b1;
            end else if (alu_done) begin
                alu_pend <= 1'b0;
            end
        end
    end

    // A drop on the same edge as a clear request leaves the flag set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf <= 1'b0;
        end else if (rd_drop || alu_drop) begin
            ovf <= 1'b1;
        end else if (CLR_OVF) begin
            ovf <= 1'b0;
        end
    end

    assign RD_PEND  = rd_pend;
    assign ALU_PEND = alu_pend;
    assign OVERFLOW = ovf;

endmodule

// File: tb/tb_tx_resp_sched.sv
// Directed bench for tx_resp_sched: each task drives one scenario and checks
// the pending flags, combinational outputs and the log of bytes written.
module tb_tx_resp_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RD_DATA;
    logic        RD_DATA_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        FIFO_FULL;
    logic        FIFO_WR;
    logic [7:0]  TX_DATA_OUT;
    logic        RD_PEND;
    logic        ALU_PEND;
    logic        OVERFLOW;
    logic        CLR_OVF;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] wr_log[$];
    int         wr_cyc[$];

    tx_resp_sched #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .FIFO_FULL(FIFO_FULL), .FIFO_WR(FIFO_WR), .TX_DATA_OUT(TX_DATA_OUT),
        .RD_PEND(RD_PEND), .ALU_PEND(ALU_PEND),
        .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Inputs only change just after a rising edge, so a write seen at the
    // falling edge is the one that transfers on the next rising edge.
    always @(negedge CLK) begin
        if (RST && FIFO_WR) begin
            wr_log.push_back(TX_DATA_OUT);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        RD_DATA_VLD = 1'b0;
        ALU_OUT_VLD = 1'b0;
        CLR_OVF     = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        idle_inputs();
        FIFO_FULL = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        RD_DATA = 8'h00;
        ALU_OUT = 16'h0000;
        idle_inputs();
        FIFO_FULL = 1'b0;
        #3;
        checks++; if (FIFO_WR !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", FIFO_WR); end
        checks++; if (TX_DATA_OUT !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", TX_DATA_OUT); end
        checks++; if ({RD_PEND, ALU_PEND, OVERFLOW} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {RD_PEND, ALU_PEND, OVERFLOW}); end
        tick();
        RST = 1'b1;
        tick();
        tick();
        checks++; if (FIFO_WR !== 1'b0 || wr_log.size() != 0) begin failures++; $display("FAIL reset_quiet got_wr=%b writes=%0d exp 0/0", FIFO_WR, wr_log.size()); end
    endtask

    task automatic test_rd_single();
        do_reset();
        RD_DATA = 8'h5A; RD_DATA_VLD = 1'b1;
        tick();
        RD_DATA_VLD = 1'b0;
        checks++; if (RD_PEND !== 1'b1 || FIFO_WR !== 1'b0) begin failures++; $display("FAIL rd_pend got=%b/%b exp=1/0", RD_PEND, FIFO_WR); end
        tick();
        checks++; if (FIFO_WR !== 1'b1 || TX_DATA_OUT !== 8'h5A) begin failures++; $display("FAIL rd_send got=%b/%h exp=1/5a", FIFO_WR, TX_DATA_OUT); end
        tick();
        checks++; if (RD_PEND !== 1'b0 || FIFO_WR !== 1'b0 || TX_DATA_OUT !== 8'h00) begin failures++; $display("FAIL rd_after got=%b/%b/%h exp=0/0/00", RD_PEND, FIFO_WR, TX_DATA_OUT); end
        repeat (4) tick();
        checks++; if (wr_log.size() != 1) begin failures++; $display("FAIL rd_count got=%0d exp=1", wr_log.size()); end
        else begin checks++; if (wr_log[0] !== 8'h5A) begin failures++; $display("FAIL rd_byte got=%h exp=5a", wr_log[0]); end end
    endtask

    task automatic test_alu_single();
        do_reset();
        ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        checks++; if (ALU_PEND !== 1'b1) begin failures++; $display("FAIL alu_pend got=%b exp=1", ALU_PEND); end
        tick();
        checks++; if (FIFO_WR !== 1'b1 || TX_DATA_OUT !== 8'h34) begin failures++; $display("FAIL alu_lo got=%b/%h exp=1/34", FIFO_WR, TX_DATA_OUT); end
        tick();
        checks++; if (FIFO_WR !== 1'b1 || TX_DATA_OUT !== 8'h12) begin failures++; $display("FAIL alu_hi got=%b/%h exp=1/12", FIFO_WR, TX_DATA_OUT); end
        tick();
        checks++; if (ALU_PEND !== 1'b0 || FIFO_WR !== 1'b0) begin failures++; $display("FAIL alu_after got=%b/%b exp=0/0", ALU_PEND, FIFO_WR); end
        repeat (3) tick();
        checks++; if (wr_log.size() != 2) begin failures++; $display("FAIL alu_count got=%0d exp=2", wr_log.size()); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b[6] = '{8'hAA, 8'hEF, 8'hBE, 8'hEF, 8'hBE, 8'hAA};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            RD_DATA = 8'hAA; RD_DATA_VLD = 1'b1;
            ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1;
            tick();
            idle_inputs();
            repeat (10) tick();
        end
        checks++; if (wr_log.size() != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", wr_log.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (wr_log[i] !== exp_b[i]) begin failures++; $display("FAIL rr_byte%0d got=%h exp=%h", i, wr_log[i], exp_b[i]); end
            end
            checks++; if (wr_cyc[2] != wr_cyc[1] + 1 || wr_cyc[4] != wr_cyc[3] + 1) begin failures++; $display("FAIL rr_alu_adjacent got=%0d,%0d/%0d,%0d exp consecutive", wr_cyc[1], wr_cyc[2], wr_cyc[3], wr_cyc[4]); end
        end
    endtask

    task automatic test_backpressure();
        int stray = 0;
        do_reset();
        ALU_OUT = 16'h0102; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        tick();
        FIFO_FULL = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (FIFO_WR !== 1'b0 || TX_DATA_OUT !== 8'h02) stray++;
            tick();
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", stray); end
        FIFO_FULL = 1'b0;
        #1;
        checks++; if (FIFO_WR !== 1'b1 || TX_DATA_OUT !== 8'h02) begin failures++; $display("FAIL bp_lo got=%b/%h exp=1/02", FIFO_WR, TX_DATA_OUT); end
        repeat (5) tick();
        checks++; if (wr_log.size() != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", wr_log.size()); end
        else begin
            checks++; if (wr_log[0] !== 8'h02 || wr_log[1] !== 8'h01) begin failures++; $display("FAIL bp_bytes got=%h,%h exp=02,01", wr_log[0], wr_log[1]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        FIFO_FULL = 1'b1;
        RD_DATA = 8'h3C; RD_DATA_VLD = 1'b1;
        tick();
        RD_DATA = 8'h77; CLR_OVF = 1'b1;
        tick();
        idle_inputs();
        checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", OVERFLOW); end
        checks++; if (RD_PEND !== 1'b1 || TX_DATA_OUT !== 8'h3C || FIFO_WR !== 1'b0) begin failures++; $display("FAIL ovf_keep got=%b/%h/%b exp=1/3c/0", RD_PEND, TX_DATA_OUT, FIFO_WR); end
        tick();
        FIFO_FULL = 1'b0;
        tick();
        repeat (2) tick();
        checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", OVERFLOW); end
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", OVERFLOW); end
        checks++; if (wr_log.size() != 1) begin failures++; $display("FAIL ovf_count got=%0d exp=1", wr_log.size()); end
        else begin checks++; if (wr_log[0] !== 8'h3C) begin failures++; $display("FAIL ovf_byte got=%h exp=3c", wr_log[0]); end end
    endtask

    task automatic test_back_to_back();
        do_reset();
        RD_DATA = 8'h01; RD_DATA_VLD = 1'b1;
        tick();
        RD_DATA_VLD = 1'b0;
        tick();
        RD_DATA = 8'h02; RD_DATA_VLD = 1'b1;
        tick();
        RD_DATA_VLD = 1'b0;
        checks++; if (RD_PEND !== 1'b1 || OVERFLOW !== 1'b0) begin failures++; $display("FAIL b2b_capture got=%b/%b exp=1/0", RD_PEND, OVERFLOW); end
        tick();
        checks++; if (FIFO_WR !== 1'b1 || TX_DATA_OUT !== 8'h02) begin failures++; $display("FAIL b2b_send got=%b/%h exp=1/02", FIFO_WR, TX_DATA_OUT); end
        repeat (3) tick();
        checks++; if (wr_log.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", wr_log.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ALU_OUT = 16'hABCD; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        tick();
        tick();
        checks++; if (FIFO_WR !== 1'b1 || TX_DATA_OUT !== 8'hAB) begin failures++; $display("FAIL mid_hi got=%b/%h exp=1/ab", FIFO_WR, TX_DATA_OUT); end
        RST = 1'b0;
        #1;
        checks++; if (FIFO_WR !== 1'b0 || TX_DATA_OUT !== 8'h00 || ALU_PEND !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%h/%b exp=0/00/0", FIFO_WR, TX_DATA_OUT, ALU_PEND); end
        tick();
        RST = 1'b1;
        repeat (6) tick();
        checks++; if (wr_log.size() != 1 || ALU_PEND !== 1'b0) begin failures++; $display("FAIL mid_abandon got writes=%0d pend=%b exp 1/0", wr_log.size(), ALU_PEND); end
        else begin checks++; if (wr_log[0] !== 8'hCD) begin failures++; $display("FAIL mid_lo_byte got=%h exp=cd", wr_log[0]); end end
    endtask

    initial begin
        test_reset();
        test_rd_single();
        test_alu_single();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
